// File: rtl/video_shift_clock_if.sv
// video_shift_clock_if: mode request and shift-clock outputs of the pixel shift clock generator
interface video_shift_clock_if;
    logic div2;
    logic vsclk;
    logic div2_active;
    modport master (output div2, input vsclk, div2_active);
    modport slave (input div2, output vsclk, div2_active);
endinterface

// File: rtl/video_shift_clock.sv
// video_shift_clock: full-rate or half-rate pixel shift clock with glitch-free mode changes
module video_shift_clock (
    input  logic clk,
    input  logic reset,
    video_shift_clock_if.slave s
);
    logic mode_q;
    logic t_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            mode_q <= 1'b0;
            t_q    <= 1'b0;
        end else if (!mode_q) begin
            if (s.div2) begin
                mode_q <= 1'b1;
                t_q    <= 1'b1;
            end
        end else if (!s.div2 && !t_q) mode_q <= 1'b0;
        else t_q <= ~t_q;
    // Mode flips only at a clk rise while the outgoing source is low, so the mux output cannot glitch
    assign s.vsclk       = reset ? 1'b0 : (mode_q ? t_q : clk);
    assign s.div2_active = mode_q;
endmodule

// File: tb/tb_video_shift_clock.sv
// tb_video_shift_clock: edge-indexed reference model plus directed and randomized mode switching
module tb_video_shift_clock;
    logic clk = 1'b0;
    logic reset = 1'b1;
    video_shift_clock_if vif ();

    video_shift_clock dut (.clk(clk), .reset(reset), .s(vif.slave));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference: half rate entered at edge e0 makes vsclk high after edges e0, e0+2, ...
    // Leaving is allowed at an edge only if vsclk was low just before it.
    bit m = 1'b0;
    bit v = 1'b0;
    int n = 0;
    int e0 = 0;
    int exp_rises = 0;
    int rises = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m = 1'b0;
            v = 1'b0;
        end else begin
            n++;
            if (!m) begin
                if (vif.div2) begin
                    m  = 1'b1;
                    e0 = n;
                end
            end else if (!vif.div2 && (n - e0) % 2 == 0) m = 1'b0;
            if (m) v = ((n - e0) % 2 == 0);
            if (!m || v) exp_rises++;
        end
    end

    initial forever begin
        @(clk);
        #1;
        check("vsclk", int'(vif.vsclk), reset ? 0 : (m ? int'(v) : int'(clk)));
        check("div2_active", int'(vif.div2_active), int'(m));
    end

    always @(posedge vif.vsclk) begin
        rises++;
        check("rise_on_clk_edge", int'(clk === 1'b1 && $time % 10 == 5), 1);
    end

    time last_edge = 0;
    bit have_edge = 1'b0;
    always @(vif.vsclk) begin
        if (reset) have_edge = 1'b0;
        else begin
            if (have_edge) check("pulse_width_ge_half", int'($time - last_edge >= 5), 1);
            have_edge = 1'b1;
            last_edge = $time;
        end
    end

    int r0;
    initial begin
        vif.div2 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_vsclk", int'(vif.vsclk), 0);
        check("reset_div2_active", int'(vif.div2_active), 0);
        reset = 1'b0;
        // full rate for 8 cycles
        r0 = rises;
        repeat (8) @(negedge clk);
        check("full_rate_rises", rises - r0, 8);
        check("full_rate_div2_active", int'(vif.div2_active), 0);
        // release with div2 high
        reset = 1'b1;
        vif.div2 = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        r0 = rises;
        @(posedge clk);
        #1 check("half_entry_div2_active", int'(vif.div2_active), 1);
        repeat (8) @(negedge clk);
        check("half_rate_rises", rises - r0, 4);
        // full to half mid-run
        vif.div2 = 1'b0;
        repeat (3) @(negedge clk);
        vif.div2 = 1'b1;
        @(posedge clk);
        #1 check("f2h_edge_n_high", int'(vif.vsclk), 1);
        check("f2h_active", int'(vif.div2_active), 1);
        @(negedge clk);
        #1 check("f2h_stays_high", int'(vif.vsclk), 1);
        @(posedge clk);
        #1 check("f2h_fall_n1", int'(vif.vsclk), 0);
        @(negedge clk);
        #1 check("f2h_low_n1", int'(vif.vsclk), 0);
        @(posedge clk);
        #1 check("f2h_rise_n2", int'(vif.vsclk), 1);
        // half to full requested while vsclk high: deferred
        @(negedge clk);
        vif.div2 = 1'b0;
        @(posedge clk);
        #1 check("h2f_defer_vsclk", int'(vif.vsclk), 0);
        check("h2f_defer_active", int'(vif.div2_active), 1);
        @(negedge clk);
        #1 check("h2f_defer_low", int'(vif.vsclk), 0);
        @(posedge clk);
        #1 check("h2f_defer_taken", int'(vif.div2_active), 0);
        check("h2f_defer_rise", int'(vif.vsclk), 1);
        // half to full requested while vsclk low: immediate
        @(negedge clk);
        vif.div2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 check("h2f_now_low", int'(vif.vsclk), 0);
        @(negedge clk);
        vif.div2 = 1'b0;
        @(posedge clk);
        #1 check("h2f_now_active", int'(vif.div2_active), 0);
        check("h2f_now_rise", int'(vif.vsclk), 1);
        // reset while vsclk high in half rate
        @(negedge clk);
        vif.div2 = 1'b1;
        @(posedge clk);
        #1 check("pre_reset_high", int'(vif.vsclk), 1);
        #1 reset = 1'b1;
        #1 check("async_reset_vsclk", int'(vif.vsclk), 0);
        check("async_reset_active", int'(vif.div2_active), 0);
        vif.div2 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("directed_rise_count", rises, exp_rises);
        // randomized mode requests and occasional resets
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if ($urandom % 4 == 0) vif.div2 = ~vif.div2;
            if ($urandom % 60 == 0) begin
                @(posedge clk);
                #($urandom_range(2, 4));
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        check("random_rise_count", rises, exp_rises);
        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end
endmodule
